// File: rtl/alu_pkg.sv
// Shared ALU / multiply-divide definitions: MIPS funct codes for HI/LO ops
// and the iterative multiply-divide controller state encoding.
package alu_pkg;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the unsigned magnitude datapath.
// Ports: is_div selects divide; hi_i/lo_i working pair in, opnd_i
// multiplicand or divisor; hi_o/lo_o working pair after the step.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;

    always_comb begin
        // Multiply: add when the multiplier LSB is set, then shift
        // {carry, hi, lo} right so the product forms in hi:lo.
        sum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
        // Divide: lo holds the dividend and collects quotient bits.
        rem_sh = {hi_i, lo_i[WIDTH-1]};
        // When the trial subtract succeeds the result is < divisor,
        // so the low WIDTH bits are exact.
        diff   = rem_sh[WIDTH-1:0] - opnd_i;
        if (is_div) begin
            if (rem_sh >= {1'b0, opnd_i}) begin
                hi_o = diff;
                lo_o = {lo_i[WIDTH-2:0], 1'b1};
            end else begin
                hi_o = rem_sh[WIDTH-1:0];
                lo_o = {lo_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_o = sum[WIDTH:1];
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO multiply-divide unit with MFHI/MFLO/MTHI/MTLO.
// Ports: start/funct/dataIn0/dataIn1 request; busy, done pulse, result
// register with zero/negative/positive flags, divByZero valid with done.
module mult_div_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] dataIn0,
    input  logic [WIDTH-1:0] dataIn1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             outputZero,
    output logic             outputNegative,
    output logic             outputPositive,
    output logic             divByZero
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mdu_state_e       state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, res_q, res_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;
    logic             is_div_q, is_div_d, div0_q, div0_d;
    logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;

    logic             is_md, is_sgn, is_dv;
    logic [WIDTH-1:0] a_mag, b_mag, step_hi, step_lo, quo, rem;
    logic [2*WIDTH-1:0] prod;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div_q),
        .hi_i   (acc_hi_q),
        .lo_i   (acc_lo_q),
        .opnd_i (opnd_q),
        .hi_o   (step_hi),
        .lo_o   (step_lo)
    );

    always_comb begin
        is_md  = funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
        is_sgn = (funct == F_MULT) || (funct == F_DIV);
        is_dv  = (funct == F_DIV) || (funct == F_DIVU);
        a_mag  = (is_sgn && dataIn0[WIDTH-1]) ? -dataIn0 : dataIn0;
        b_mag  = (is_sgn && dataIn1[WIDTH-1]) ? -dataIn1 : dataIn1;
        prod   = {acc_hi_q, acc_lo_q};
        if (neg_res_q) prod = -prod;
        // Divide by zero leaves |dividend| in acc_hi, so the normal
        // remainder sign fix already yields HI = dataIn0.
        quo = div0_q ? '1 : (neg_res_q ? -acc_lo_q : acc_lo_q);
        rem = neg_rem_q ? -acc_hi_q : acc_hi_q;
    end

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        res_d     = res_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        is_div_d  = is_div_q;
        div0_d    = div0_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    unique case (1'b1)
                        is_md: begin
                            state_d   = S_CALC;
                            busy_d    = 1'b1;
                            cnt_d     = '0;
                            is_div_d  = is_dv;
                            acc_hi_d  = '0;
                            acc_lo_d  = is_dv ? a_mag : b_mag;
                            opnd_d    = is_dv ? b_mag : a_mag;
                            neg_res_d = is_sgn &&
                                (dataIn0[WIDTH-1] ^ dataIn1[WIDTH-1]);
                            neg_rem_d = is_sgn && is_dv && dataIn0[WIDTH-1];
                            div0_d    = is_dv && (dataIn1 == '0);
                        end
                        (funct == F_MFHI): begin
                            res_d  = hi_q;
                            done_d = 1'b1;
                            dz_d   = 1'b0;
                        end
                        (funct == F_MFLO): begin
                            res_d  = lo_q;
                            done_d = 1'b1;
                            dz_d   = 1'b0;
                        end
                        (funct == F_MTHI): begin
                            hi_d   = dataIn0;
                            done_d = 1'b1;
                            dz_d   = 1'b0;
                        end
                        (funct == F_MTLO): begin
                            lo_d   = dataIn0;
                            done_d = 1'b1;
                            dz_d   = 1'b0;
                        end
                        default: begin
                            done_d = 1'b1;
                            dz_d   = 1'b0;
                        end
                    endcase
                end
            end
            S_CALC: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                if (cnt_q == LAST) state_d = S_FIXUP;
                else cnt_d = cnt_q + 1'b1;
            end
            S_FIXUP: begin
                if (is_div_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                dz_d    = is_div_q && div0_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            res_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            res_q     <= res_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            is_div_q  <= is_div_d;
            div0_q    <= div0_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign result         = res_q;
    assign divByZero      = dz_q;
    assign outputZero     = (res_q == '0);
    assign outputNegative = res_q[WIDTH-1];
    assign outputPositive = (res_q != '0) && !res_q[WIDTH-1];

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vectors plus random ops checked
// against an arithmetic HI/LO/result model.
module tb_mult_div_unit;

    localparam logic [5:0] MFHI  = 6'h10;
    localparam logic [5:0] MTHI  = 6'h11;
    localparam logic [5:0] MFLO  = 6'h12;
    localparam logic [5:0] MTLO  = 6'h13;
    localparam logic [5:0] MULT  = 6'h18;
    localparam logic [5:0] MULTU = 6'h19;
    localparam logic [5:0] DIV   = 6'h1A;
    localparam logic [5:0] DIVU  = 6'h1B;
    localparam int         LAT   = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] dataIn0, dataIn1;
    logic        busy, done;
    logic [31:0] result;
    logic        outputZero, outputNegative, outputPositive, divByZero;

    int n_chk = 0;
    int n_bad = 0;

    logic [31:0] hi_m, lo_m, res_m;
    logic        dz_m;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .funct          (funct),
        .dataIn0        (dataIn0),
        .dataIn1        (dataIn1),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .outputZero     (outputZero),
        .outputNegative (outputNegative),
        .outputPositive (outputPositive),
        .divByZero      (divByZero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_zero"}, outputZero, res_m == 0);
        chk({tag, "_neg"}, outputNegative, res_m[31]);
        chk({tag, "_pos"}, outputPositive, res_m != 0 && !res_m[31]);
    endtask

    task automatic model(input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b);
        int               sa, sb;
        longint           ps;
        longint unsigned  pu;
        sa   = a;
        sb   = b;
        dz_m = 1'b0;
        case (f)
            MULT: begin
                ps   = longint'(sa) * longint'(sb);
                hi_m = ps[63:32];
                lo_m = ps[31:0];
            end
            MULTU: begin
                pu   = {32'd0, a} * {32'd0, b};
                hi_m = pu[63:32];
                lo_m = pu[31:0];
            end
            DIV: begin
                if (b == 0) begin
                    lo_m = '1; hi_m = a; dz_m = 1'b1;
                end else if (a == 32'h8000_0000 && b == '1) begin
                    lo_m = a; hi_m = 0;
                end else begin
                    lo_m = sa / sb; hi_m = sa % sb;
                end
            end
            DIVU: begin
                if (b == 0) begin
                    lo_m = '1; hi_m = a; dz_m = 1'b1;
                end else begin
                    lo_m = a / b; hi_m = a % b;
                end
            end
            MFHI: res_m = hi_m;
            MFLO: res_m = lo_m;
            MTHI: hi_m = a;
            MTLO: lo_m = a;
            default: ;
        endcase
    endtask

    // inj > 0 drives a DIVU start just before edge inj of the operation.
    task automatic do_op(input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input int inj);
        int k;
        bit iter;
        iter    = (f == MULT || f == MULTU || f == DIV || f == DIVU);
        funct   = f;
        dataIn0 = a;
        dataIn1 = b;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model(f, a, b);
        if (iter) begin
            chk("busy_start", busy, 1);
            k = 0;
            while (!done && k < 100) begin
                if (inj > 0 && k == inj - 1) begin
                    funct   = DIVU;
                    dataIn0 = $urandom;
                    dataIn1 = $urandom;
                    start   = 1'b1;
                end
                @(posedge clk); #1;
                start = 1'b0;
                k++;
            end
            chk("latency", k, LAT);
            chk("busy_at_done", busy, 0);
            chk("dz_at_done", divByZero, dz_m);
        end else begin
            chk("done_single", done, 1);
            chk("dz_single", divByZero, 0);
            chk("result", result, res_m);
            chk_flags("flags");
        end
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
    endtask

    task automatic expect_hilo(input logic [31:0] h, input logic [31:0] l);
        do_op(MFHI, $urandom, $urandom, 0);
        chk("hi_vec", result, h);
        do_op(MFLO, $urandom, $urandom, 0);
        chk("lo_vec", result, l);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0] ops [11];
        logic [5:0] f;
        int         seen;
        ops = '{MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO,
                MULT, DIV, 6'h3F};
        rst = 1'b0; start = 1'b0; funct = '0; dataIn0 = '0; dataIn1 = '0;
        hi_m = '0; lo_m = '0; res_m = '0; dz_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_dz", divByZero, 0);
        chk_flags("rst");
        rst = 1'b1;
        @(posedge clk); #1;

        do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        expect_hilo(32'hFFFF_FFFE, 32'h0000_0001);
        do_op(MFHI, 0, 0, 0);
        chk("mfhi_neg", outputNegative, 1);
        do_op(MULT, 32'hFFFF_FFFD, 32'd7, 0);
        expect_hilo(32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op(DIV, 32'hFFFF_FFF9, 32'd2, 0);
        expect_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op(DIVU, 32'd7, 32'd2, 0);
        expect_hilo(32'd1, 32'd3);
        do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("minneg_dz", divByZero, 0);
        expect_hilo(32'd0, 32'h8000_0000);
        do_op(DIV, 32'd5, 32'd0, 0);
        expect_hilo(32'd5, 32'hFFFF_FFFF);
        do_op(MULTU, 32'd2, 32'd3, 0);
        expect_hilo(32'd0, 32'd6);
        do_op(MULT, 32'd4, 32'd4, 5);
        expect_hilo(32'd0, 32'd16);
        do_op(MTHI, 32'h8000_0000, 32'd0, 0);
        do_op(MFHI, 0, 0, 0);
        chk("mthi_val", result, 32'h8000_0000);
        chk("mthi_neg", outputNegative, 1);
        do_op(6'h3F, $urandom, $urandom, 0);

        for (int i = 0; i < 30; i++) begin
            f = ops[$urandom_range(0, 10)];
            do_op(f, pick(), pick(), 0);
            if (f == MULT || f == MULTU || f == DIV || f == DIVU) begin
                do_op(MFHI, 0, 0, 0);
                do_op(MFLO, 0, 0, 0);
            end
        end

        funct = MULT; dataIn0 = 32'd9; dataIn1 = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        hi_m = '0; lo_m = '0; res_m = '0; dz_m = 1'b0;
        @(posedge clk); #1;
        rst  = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("abort_no_done", seen, 0);
        expect_hilo(32'd0, 32'd0);
        chk("post_rst_zero", outputZero, 1);
        do_op(MULTU, 32'd3, 32'd5, 0);
        expect_hilo(32'd0, 32'd15);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
